vector_pair_loader: RTL

- Serial-to-parallel writer that feeds the combinational vector dot-product unit.
- Accepts one (a, b) element pair per handshake over a valid/ready stream and assembles vec1/vec2 element by element.
- Once VECTOR_SIZE pairs are collected, presents both vectors as stable, flattened buses under an out_valid/out_ready handshake, ready for a downstream dot-product stage.

---
 rtl/vector_pair_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vector_pair_loader.sv
// vector_pair_loader: collects (a, b) element pairs one per handshake and
// presents the two assembled vectors as stable flattened buses.
module vector_pair_loader #(
  parameter int VECTOR_SIZE = 4,
  parameter int ELEM_WIDTH  = 31,
  parameter int CNT_W       = $clog2(VECTOR_SIZE + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ELEM_WIDTH-1:0]             in_a,
  input  logic [ELEM_WIDTH-1:0]             in_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [VECTOR_SIZE*ELEM_WIDTH-1:0] vec1,
  output logic [VECTOR_SIZE*ELEM_WIDTH-1:0] vec2,
  output logic [CNT_W-1:0]                  fill_count
);

  localparam int VW = VECTOR_SIZE * ELEM_WIDTH;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(VECTOR_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(VECTOR_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [VW-1:0]     vec1_q, vec1_d;
  logic [VW-1:0]     vec2_q, vec2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      fill_q      <= '0;
      vec1_q      <= '0;
      vec2_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fill_q      <= fill_d;
      vec1_q      <= vec1_d;
      vec2_q      <= vec2_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    fill_d      = fill_q;
    vec1_d      = vec1_q;
    vec2_d      = vec2_q;

    unique case (state_q)
      IDLE: begin
        state_d    = FILL;
        in_ready_d = 1'b1;
      end

      FILL: begin
        in_ready_d = 1'b1;
        if (clear) begin
          fill_d = '0;
          vec1_d = '0;
          vec2_d = '0;
        end else if (in_valid) begin
          // Slot select by compare keeps the write a plain decoder.
          for (int k = 0; k < VECTOR_SIZE; k++) begin
            if (fill_q == CNT_W'(k)) begin
              vec1_d[k*ELEM_WIDTH +: ELEM_WIDTH] = in_a;
              vec2_d[k*ELEM_WIDTH +: ELEM_WIDTH] = in_b;
            end
          end
          if (fill_q == LAST) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            fill_d      = FULL;
          end else begin
            fill_d = fill_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        out_valid_d = 1'b1;
        if (clear) begin
          state_d     = FILL;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          fill_d      = '0;
          vec1_d      = '0;
          vec2_d      = '0;
        end else if (out_ready) begin
          // Old contents stay; they are overwritten slot by slot.
          state_d     = FILL;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          fill_d      = '0;
        end
      end

      default: begin
        state_d = IDLE;
        fill_d  = '0;
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign fill_count = fill_q;
  assign vec1       = vec1_q;
  assign vec2       = vec2_q;

endmodule
